// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction-fetch path.
package mips_pkg;
   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;
   localparam int ENTRY_W = ADDR_W + INSTR_W;

   localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] word_align(
      input logic [ADDR_W-1:0] a
   );
      return {a[ADDR_W-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/mips_fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with synchronous flush.
// Simultaneous push and pop is legal when full.
module mips_fetch_fifo
   import mips_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               push,
   input  logic [ENTRY_W-1:0] push_data,
   input  logic               pop,
   output logic [ENTRY_W-1:0] head,
   output logic [CW-1:0]      count,
   output logic               full,
   output logic               empty
);

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [ENTRY_W-1:0] mem_d [DEPTH];
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic               do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: PC, credit-limited imem requests, prefetch FIFO.
// Optional perf counters are enabled with MIPS_FETCH_PERF_EN.
module mips_fetch_unit
   import mips_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_pc,
   output logic [31:0] dec_instr
`ifdef MIPS_FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_redirects,
   output logic [31:0] perf_stall
`endif
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [CW-1:0]      out_q, out_d;
   logic [CW-1:0]      drop_q, drop_d;
   logic [CW-1:0]      fifo_count;
   logic               fifo_full, fifo_empty;
   logic               fifo_push;
   logic [ENTRY_W-1:0] head_w, push_w;
   fetch_entry_t       head_e, push_e;
   logic [CW:0]        credit_used;
   logic               req_fire, rsp_keep, pop;

   assign credit_used    = {1'b0, fifo_count} + {1'b0, out_q};
   assign imem_req_valid = !rst && !redirect_valid
                        && (credit_used < (CW+1)'(DEPTH));
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign rsp_keep  = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
   assign fifo_push = rsp_keep && (!fifo_full || pop);

   assign dec_valid = !rst && !fifo_empty && !redirect_valid;
   assign pop       = dec_valid && dec_ready;
   assign head_e    = head_w;
   assign dec_pc    = fifo_empty ? '0 : head_e.pc;
   assign dec_instr = fifo_empty ? NOP : head_e.instr;

   // Oldest live request sits 4*outstanding below the next fetch address.
   always_comb begin
      push_e.pc    = pc_q - ADDR_W'({out_q, 2'b00});
      push_e.instr = imem_rsp_data;
   end
   assign push_w = push_e;

   always_comb begin
      pc_d   = pc_q;
      drop_d = drop_q;
      out_d  = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
      if (req_fire) begin
         pc_d = pc_q + 32'd4;
      end
      if (redirect_valid) begin
         pc_d   = word_align(redirect_pc);
         // Everything still in flight after this cycle is stale,
         // including requests already marked for dropping.
         drop_d = out_q - CW'(imem_rsp_valid);
      end else if (imem_rsp_valid && (drop_q != '0)) begin
         drop_d = drop_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         out_q  <= '0;
         drop_q <= '0;
      end else begin
         pc_q   <= pc_d;
         out_q  <= out_d;
         drop_q <= drop_d;
      end
   end

   mips_fetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (fifo_push),
      .push_data (push_w),
      .pop       (pop),
      .head      (head_w),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

`ifdef MIPS_FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_redirects_q, perf_redirects_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_fetched_d   = perf_fetched_q + 32'(pop);
      perf_redirects_d = perf_redirects_q + 32'(redirect_valid);
      perf_stall_d     = perf_stall_q + 32'(dec_ready && !dec_valid);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched_q   <= '0;
         perf_redirects_q <= '0;
         perf_stall_q     <= '0;
      end else begin
         perf_fetched_q   <= perf_fetched_d;
         perf_redirects_q <= perf_redirects_d;
         perf_stall_q     <= perf_stall_d;
      end
   end

   assign perf_fetched   = perf_fetched_q;
   assign perf_redirects = perf_redirects_q;
   assign perf_stall     = perf_stall_q;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed and randomized bench for mips_fetch_unit with an in-order
// variable-latency instruction memory model.
`timescale 1ns/1ps
module tb_mips_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_pc;
   logic [31:0] dec_instr;
`ifdef MIPS_FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_redirects;
   logic [31:0] perf_stall;
`endif

   always #5 clk = ~clk;

   mips_fetch_unit #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_pc         (dec_pc),
      .dec_instr      (dec_instr)
`ifdef MIPS_FETCH_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_redirects (perf_redirects),
      .perf_stall     (perf_stall)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   // kind: 0 = pop/request, 1 = redirect, 2 = reset
   typedef struct {
      int          kind;
      logic [31:0] pc;
      logic [31:0] instr;
      int          cyc;
   } ev_t;

   mreq_t       memq[$];
   ev_t         log[$];
   ev_t         reqs[$];
   int          cyc, lat, last_due;
   int          vecs, errs;
   logic        rst_v, rdy, dready, redir;
   logic [31:0] rpc;
   int unsigned m_fetched, m_redir, m_stall;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
   endfunction

   task automatic settle();
      rst            = rst_v;
      imem_req_ready = rdy;
      dec_ready      = dready;
      redirect_valid = redir;
      redirect_pc    = rpc;
      #1;
   endtask

   task automatic cycle();
      int due;
      settle();
      if (rst_v) begin
         log.push_back('{2, 32'h0, 32'h0, cyc});
         m_fetched = 0;
         m_redir   = 0;
         m_stall   = 0;
      end else begin
         if (imem_req_valid && imem_req_ready) begin
            due = cyc + lat;
            if (due < last_due) due = last_due;
            last_due = due;
            memq.push_back('{imem_req_addr, due});
            reqs.push_back('{0, imem_req_addr, 32'h0, cyc});
         end
         if (dec_valid && dec_ready) begin
            log.push_back('{0, dec_pc, dec_instr, cyc});
            m_fetched++;
         end
         if (redir) begin
            log.push_back('{1, rpc, 32'h0, cyc});
            m_redir++;
         end
         if (dready && !dec_valid) m_stall++;
      end
      @(posedge clk);
      #1;
      cyc++;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if (rst_v) begin
         memq.delete();
         last_due = 0;
      end else if (memq.size() > 0 && memq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(memq[0].addr);
         void'(memq.pop_front());
      end
   endtask

   task automatic do_reset();
      rst_v  = 1'b1;
      redir  = 1'b0;
      rdy    = 1'b0;
      dready = 1'b0;
      cycle();
      cycle();
      rst_v = 1'b0;
      log.delete();
      reqs.delete();
   endtask

   task automatic test_reset();
      rst_v  = 1'b1;
      rdy    = 1'b1;
      dready = 1'b1;
      redir  = 1'b0;
      rpc    = 32'h0;
      lat    = 1;
      cycle();
      cycle();
      settle();
      vecs++;
      if (imem_req_valid !== 1'b0) begin
         errs++;
         $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid);
      end
      vecs++;
      if (dec_valid !== 1'b0) begin
         errs++;
         $display("FAIL reset_dec_valid: got %b expected 0", dec_valid);
      end
      rst_v = 1'b0;
      settle();
      vecs++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         errs++;
         $display("FAIL reset_first_req: got v=%b a=%h expected v=1 a=00000000",
                  imem_req_valid, imem_req_addr);
      end
      vecs++;
      if (dec_valid !== 1'b0) begin
         errs++;
         $display("FAIL reset_release_dec_valid: got %b expected 0", dec_valid);
      end
      log.delete();
      reqs.delete();
   endtask

   task automatic test_stream();
      int base;
      do_reset();
      lat    = 1;
      rdy    = 1'b1;
      dready = 1'b1;
      base   = cyc;
      repeat (12) cycle();
      vecs++;
      if (log.size() != 10) begin
         errs++;
         $display("FAIL stream_count: got %0d pops expected 10", log.size());
      end
      for (int i = 0; i < log.size(); i++) begin
         vecs++;
         if (log[i].kind != 0 || log[i].pc !== 32'(4 * i)
             || log[i].instr !== mem_word(32'(4 * i))
             || log[i].cyc != base + 2 + i) begin
            errs++;
            $display("FAIL stream_pop[%0d]: got pc=%h instr=%h cyc=%0d expected pc=%h instr=%h cyc=%0d",
                     i, log[i].pc, log[i].instr, log[i].cyc,
                     32'(4 * i), mem_word(32'(4 * i)), base + 2 + i);
         end
      end
   endtask

   task automatic test_full_stall();
      int n;
      do_reset();
      lat    = 1;
      rdy    = 1'b1;
      dready = 1'b0;
      repeat (20) cycle();
      settle();
      vecs++;
      if (reqs.size() != 4) begin
         errs++;
         $display("FAIL stall_req_count: got %0d expected 4", reqs.size());
      end
      for (int i = 0; i < reqs.size(); i++) begin
         vecs++;
         if (reqs[i].pc !== 32'(4 * i)) begin
            errs++;
            $display("FAIL stall_req_addr[%0d]: got %h expected %h",
                     i, reqs[i].pc, 32'(4 * i));
         end
      end
      vecs++;
      if (imem_req_valid !== 1'b0) begin
         errs++;
         $display("FAIL stall_req_valid: got %b expected 0", imem_req_valid);
      end
      vecs++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_instr !== mem_word(32'h0)) begin
         errs++;
         $display("FAIL stall_head: got v=%b pc=%h instr=%h expected v=1 pc=00000000 instr=%h",
                  dec_valid, dec_pc, dec_instr, mem_word(32'h0));
      end
      vecs++;
      if (log.size() != 0) begin
         errs++;
         $display("FAIL stall_no_pop: got %0d pops expected 0", log.size());
      end
      n      = reqs.size();
      dready = 1'b1;
      repeat (10) cycle();
      vecs++;
      if (reqs.size() <= n || reqs[n].pc !== 32'h10) begin
         errs++;
         $display("FAIL stall_resume_addr: got %h expected 00000010",
                  (reqs.size() > n) ? reqs[n].pc : 32'hxxxx_xxxx);
      end
      for (int i = 0; i < 5; i++) begin
         vecs++;
         if (log.size() <= i || log[i].pc !== 32'(4 * i)
             || log[i].instr !== mem_word(32'(4 * i))) begin
            errs++;
            $display("FAIL stall_release_pop[%0d]: got pc=%h expected %h",
                     i, (log.size() > i) ? log[i].pc : 32'hxxxx_xxxx, 32'(4 * i));
         end
      end
   endtask

   task automatic test_redirect_drop();
      int          rc, npop, k;
      logic [31:0] exp;
      do_reset();
      lat    = 3;
      rdy    = 1'b1;
      dready = 1'b1;
      repeat (3) cycle();
      vecs++;
      if (reqs.size() != 3) begin
         errs++;
         $display("FAIL drop_inflight: got %0d expected 3", reqs.size());
      end
      redir = 1'b1;
      rpc   = 32'h400;
      rc    = cyc;
      cycle();
      redir = 1'b0;
      repeat (20) cycle();
      exp  = 32'h400;
      npop = 0;
      for (int i = 0; i < log.size(); i++) begin
         if (log[i].kind == 0) begin
            vecs++;
            npop++;
            if (log[i].pc !== exp || log[i].instr !== mem_word(exp)) begin
               errs++;
               $display("FAIL drop_pop[%0d]: got pc=%h instr=%h expected pc=%h instr=%h",
                        i, log[i].pc, log[i].instr, exp, mem_word(exp));
            end
            exp = exp + 32'd4;
         end
      end
      vecs++;
      if (npop < 4) begin
         errs++;
         $display("FAIL drop_pop_count: got %0d expected at least 4", npop);
      end
      k = -1;
      for (int i = 0; i < reqs.size(); i++) begin
         if (k < 0 && reqs[i].cyc > rc) k = i;
      end
      vecs++;
      if (k < 0 || reqs[k].pc !== 32'h400 || reqs[k].cyc != rc + 1) begin
         errs++;
         $display("FAIL drop_first_req: got idx=%0d expected addr 00000400 at cyc %0d", k, rc + 1);
      end
   endtask

   task automatic test_redirect_coincident();
      int          npre, seen;
      logic [31:0] exp;
      do_reset();
      lat    = 1;
      rdy    = 1'b1;
      dready = 1'b1;
      repeat (4) cycle();
      redir = 1'b1;
      rpc   = 32'h203;
      settle();
      vecs++;
      if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
         errs++;
         $display("FAIL coinc_redirect_cycle: got dec_v=%b req_v=%b expected 0 0",
                  dec_valid, imem_req_valid);
      end
      cycle();
      redir = 1'b0;
      settle();
      vecs++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
         errs++;
         $display("FAIL coinc_next_req: got v=%b a=%h expected v=1 a=00000200",
                  imem_req_valid, imem_req_addr);
      end
      repeat (8) cycle();
      npre = 0;
      seen = 0;
      exp  = 32'h0;
      for (int i = 0; i < log.size(); i++) begin
         if (log[i].kind == 1) begin
            seen = 1;
            exp  = 32'h200;
         end else if (log[i].kind == 0) begin
            if (seen == 0) npre++;
            vecs++;
            if (log[i].pc !== exp || log[i].instr !== mem_word(exp)) begin
               errs++;
               $display("FAIL coinc_pop[%0d]: got pc=%h instr=%h expected pc=%h",
                        i, log[i].pc, log[i].instr, exp);
            end
            exp = exp + 32'd4;
         end
      end
      vecs++;
      if (npre != 2) begin
         errs++;
         $display("FAIL coinc_pre_pops: got %0d expected 2", npre);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] want [3];
      int          k;
      want[0] = 32'hFFFF_FFF8;
      want[1] = 32'hFFFF_FFFC;
      want[2] = 32'h0000_0000;
      do_reset();
      lat    = 1;
      rdy    = 1'b1;
      dready = 1'b1;
      redir  = 1'b1;
      rpc    = 32'hFFFF_FFF8;
      cycle();
      redir = 1'b0;
      repeat (8) cycle();
      for (int i = 0; i < 3; i++) begin
         vecs++;
         if (reqs.size() <= i || reqs[i].pc !== want[i]) begin
            errs++;
            $display("FAIL wrap_req[%0d]: got %h expected %h",
                     i, (reqs.size() > i) ? reqs[i].pc : 32'hxxxx_xxxx, want[i]);
         end
      end
      k = 0;
      for (int i = 0; i < log.size(); i++) begin
         if (log[i].kind == 0 && k < 3) begin
            vecs++;
            if (log[i].pc !== want[k] || log[i].instr !== mem_word(want[k])) begin
               errs++;
               $display("FAIL wrap_pop[%0d]: got pc=%h expected %h", k, log[i].pc, want[k]);
            end
            k++;
         end
      end
      vecs++;
      if (k != 3) begin
         errs++;
         $display("FAIL wrap_pop_count: got %0d expected 3", k);
      end
   endtask

   task automatic test_random();
      logic [31:0] exp;
      int          npop;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         lat    = $urandom_range(1, 4);
         rdy    = ($urandom_range(0, 3) != 0);
         dready = ($urandom_range(0, 3) != 0);
         redir  = ($urandom_range(0, 24) == 0);
         rpc    = $urandom();
         rst_v  = (i == 400);
         if (rst_v) redir = 1'b0;
         cycle();
         if (i == 400) begin
            settle();
            vecs++;
            if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0) begin
               errs++;
               $display("FAIL rand_mid_reset: got req_v=%b dec_v=%b expected 0 0",
                        imem_req_valid, dec_valid);
            end
            rst_v = 1'b0;
            redir = 1'b0;
            rdy   = 1'b0;
            settle();
            vecs++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || dec_valid !== 1'b0) begin
               errs++;
               $display("FAIL rand_restart: got req_v=%b a=%h dec_v=%b expected 1 00000000 0",
                        imem_req_valid, imem_req_addr, dec_valid);
            end
         end
      end
      rst_v = 1'b0;
      redir = 1'b0;
      exp   = 32'h0;
      npop  = 0;
      for (int i = 0; i < log.size(); i++) begin
         if (log[i].kind == 2) begin
            exp = 32'h0;
         end else if (log[i].kind == 1) begin
            exp = log[i].pc & 32'hFFFF_FFFC;
         end else begin
            vecs++;
            npop++;
            if (log[i].pc !== exp || log[i].instr !== mem_word(exp)) begin
               errs++;
               $display("FAIL rand_pop[%0d]: got pc=%h instr=%h expected pc=%h instr=%h",
                        i, log[i].pc, log[i].instr, exp, mem_word(exp));
            end
            exp = exp + 32'd4;
         end
      end
      vecs++;
      if (npop < 100) begin
         errs++;
         $display("FAIL rand_pop_count: got %0d expected at least 100", npop);
      end
`ifdef MIPS_FETCH_PERF_EN
      settle();
      vecs++;
      if (perf_fetched !== 32'(m_fetched) || perf_redirects !== 32'(m_redir)
          || perf_stall !== 32'(m_stall)) begin
         errs++;
         $display("FAIL rand_perf: got f=%0d r=%0d s=%0d expected f=%0d r=%0d s=%0d",
                  perf_fetched, perf_redirects, perf_stall, m_fetched, m_redir, m_stall);
      end
`endif
   endtask

   initial begin
      vecs           = 0;
      errs           = 0;
      cyc            = 0;
      last_due       = 0;
      lat            = 1;
      rst_v          = 1'b1;
      rdy            = 1'b0;
      dready         = 1'b0;
      redir          = 1'b0;
      rpc            = 32'h0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      m_fetched      = 0;
      m_redir        = 0;
      m_stall        = 0;
      settle();
      test_reset();
      test_stream();
      test_full_stall();
      test_redirect_drop();
      test_redirect_coincident();
      test_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
